// File: rtl/u_rf_sb.sv
// u_rf_sb: parametrised register file with per-register pending scoreboard.
// Define U_RF_BYPASS_EN to forward the writeback port onto the read ports in the writeback cycle.
module u_rf_sb #(
    parameter int XLEN = 32,
    parameter int NREG = 32,
    localparam int AW = $clog2(NREG),
    localparam int CW = $clog2(NREG + 1)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [AW-1:0]   rs1_a,
    input  logic [AW-1:0]   rs2_a,
    output logic [XLEN-1:0] rs1_o,
    output logic [XLEN-1:0] rs2_o,
    output logic            rs1_rdy,
    output logic            rs2_rdy,
    input  logic            iss_e,
    input  logic [AW-1:0]   iss_a,
    input  logic            rd_e,
    input  logic [AW-1:0]   rd_a,
    input  logic [XLEN-1:0] rd_i,
    input  logic            flush,
    output logic [CW-1:0]   pend_cnt
);
    logic [XLEN-1:0] mem [NREG];
    logic [NREG-1:0] pend, pend_nxt;
    logic [CW-1:0]   cnt;
    logic            wr, is, inc, dec, hit1, hit2;

    assign wr  = rd_e && rd_a != '0;
    assign is  = iss_e && iss_a != '0;
    // A writeback only lowers the count if the same edge does not re-mark that register.
    assign inc = is && !pend[iss_a];
    assign dec = wr && pend[rd_a] && !(is && iss_a == rd_a);

    always_comb begin
        pend_nxt = flush ? '0 : pend;
        if (wr) pend_nxt[rd_a] = 1'b0;
        if (is) pend_nxt[iss_a] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) mem[i] <= '0;
            pend <= '0;
            cnt  <= '0;
        end else begin
            if (wr) mem[rd_a] <= rd_i;
            pend <= pend_nxt;
            cnt  <= flush ? CW'(is) : cnt + CW'(inc) - CW'(dec);
        end
    end

`ifdef U_RF_BYPASS_EN
    assign hit1 = rd_e && rd_a == rs1_a;
    assign hit2 = rd_e && rd_a == rs2_a;
`else
    assign hit1 = 1'b0;
    assign hit2 = 1'b0;
`endif

    assign rs1_o    = rs1_a == '0 ? '0 : hit1 ? rd_i : mem[rs1_a];
    assign rs2_o    = rs2_a == '0 ? '0 : hit2 ? rd_i : mem[rs2_a];
    assign rs1_rdy  = rs1_a == '0 || !pend[rs1_a] || hit1;
    assign rs2_rdy  = rs2_a == '0 || !pend[rs2_a] || hit2;
    assign pend_cnt = cnt;
endmodule

// File: tb/tb_u_rf_sb.sv
// tb_u_rf_sb: directed scoreboard bench for u_rf_sb; expectations follow U_RF_BYPASS_EN.
module tb_u_rf_sb;
`ifdef U_RF_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif
    localparam int S_O1 = 0, S_R1 = 1, S_O2 = 2, S_R2 = 3, S_CNT = 4;

    logic        clk = 1'b0;
    logic        rst, iss_e, rd_e, flush;
    logic [4:0]  rs1_a, rs2_a, iss_a, rd_a;
    logic [31:0] rd_i, rs1_o, rs2_o;
    logic        rs1_rdy, rs2_rdy;
    logic [5:0]  pend_cnt;

    typedef struct {
        string       tag;
        int          sel;
        logic [31:0] val;
    } exp_t;
    exp_t sb[$];
    int checks = 0;
    int failures = 0;

    u_rf_sb dut (
        .clk(clk), .rst(rst), .rs1_a(rs1_a), .rs2_a(rs2_a), .rs1_o(rs1_o), .rs2_o(rs2_o),
        .rs1_rdy(rs1_rdy), .rs2_rdy(rs2_rdy), .iss_e(iss_e), .iss_a(iss_a), .rd_e(rd_e),
        .rd_a(rd_a), .rd_i(rd_i), .flush(flush), .pend_cnt(pend_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] observe(int sel);
        return sel == S_O1 ? rs1_o : sel == S_R1 ? 32'(rs1_rdy) : sel == S_O2 ? rs2_o :
               sel == S_R2 ? 32'(rs2_rdy) : 32'(pend_cnt);
    endfunction

    task automatic exp(string tag, int sel, logic [31:0] val);
        sb.push_back('{tag, sel, val});
    endtask

    task automatic drain();
        exp_t e;
        logic [31:0] obs;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            obs = observe(e.sel);
            checks++;
            assert (obs === e.val) else begin
                failures++;
                $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.val);
            end
        end
    endtask

    // evaluate current inputs mid-cycle, then take the next edge
    task automatic step();
        #2;
        drain();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        rst = 0; iss_e = 0; rd_e = 0; flush = 0;
    endtask

    initial begin
        rst = 1; iss_e = 0; iss_a = 0; rd_e = 0; rd_a = 0; rd_i = 0; flush = 0;
        rs1_a = 5'd5; rs2_a = 5'd31;
        repeat (2) @(posedge clk);
        #1;
        exp("rst_o1", S_O1, 0); exp("rst_r1", S_R1, 1);
        exp("rst_o2", S_O2, 0); exp("rst_r2", S_R2, 1); exp("rst_cnt", S_CNT, 0);
        step();
        idle();
        for (int a = 0; a < 32; a++) begin
            rs1_a = 5'(a); rs2_a = 5'(31 - a);
            exp($sformatf("init_o1_x%0d", a), S_O1, 0); exp($sformatf("init_r1_x%0d", a), S_R1, 1);
            exp($sformatf("init_o2_x%0d", a), S_O2, 0); exp($sformatf("init_r2_x%0d", a), S_R2, 1);
            exp("init_cnt", S_CNT, 0);
            step();
        end
        // issue x5, observe pending, then write it back
        iss_e = 1; iss_a = 5; rs1_a = 5; rs2_a = 0;
        exp("iss5_same_r1", S_R1, 1); exp("iss5_same_cnt", S_CNT, 0);
        step();
        iss_e = 0;
        for (int c = 1; c <= 3; c++) begin
            exp($sformatf("iss5_c%0d_r1", c), S_R1, 0); exp($sformatf("iss5_c%0d_cnt", c), S_CNT, 1);
            step();
        end
        rd_e = 1; rd_a = 5; rd_i = 32'hDEADBEEF;
        exp("wb5_o1", S_O1, BYP ? 32'hDEADBEEF : 32'h0); exp("wb5_r1", S_R1, BYP);
        exp("wb5_cnt", S_CNT, 1);
        step();
        idle();
        exp("wb5_next_o1", S_O1, 32'hDEADBEEF); exp("wb5_next_r1", S_R1, 1);
        exp("wb5_next_cnt", S_CNT, 0);
        step();
        // x7: pending, then issue and writeback in the same cycle
        iss_e = 1; iss_a = 7; rs2_a = 7;
        step();
        rd_e = 1; rd_a = 7; rd_i = 32'h11;
        exp("iw7_o2", S_O2, BYP ? 32'h11 : 32'h0); exp("iw7_r2", S_R2, BYP);
        exp("iw7_cnt", S_CNT, 1);
        step();
        idle();
        exp("iw7_next_o2", S_O2, 32'h11); exp("iw7_next_r2", S_R2, 0);
        exp("iw7_next_cnt", S_CNT, 1);
        step();
        rd_e = 1; rd_a = 7; rd_i = 32'h33;
        exp("wb7_o2", S_O2, BYP ? 32'h33 : 32'h11); exp("wb7_r2", S_R2, BYP);
        step();
        idle();
        exp("wb7_next_o2", S_O2, 32'h33); exp("wb7_next_r2", S_R2, 1);
        exp("wb7_next_cnt", S_CNT, 0);
        step();
        // x0 writes and issues are ignored
        rd_e = 1; rd_a = 0; rd_i = 32'hFFFFFFFF; iss_e = 1; iss_a = 0; rs1_a = 0; rs2_a = 0;
        exp("x0_same_o1", S_O1, 0); exp("x0_same_r1", S_R1, 1);
        step();
        idle();
        exp("x0_o1", S_O1, 0); exp("x0_r1", S_R1, 1); exp("x0_cnt", S_CNT, 0);
        step();
        // write a non-pending register, then a stale rd_a must not forward
        rd_e = 1; rd_a = 3; rd_i = 32'h12345678;
        step();
        idle();
        rd_a = 3; rd_i = 32'hAAAA5555; rs1_a = 3;
        exp("stale_o1", S_O1, 32'h12345678); exp("stale_r1", S_R1, 1); exp("stale_cnt", S_CNT, 0);
        step();
        // issue x1..x4, then flush together with iss x9
        for (int r = 1; r <= 4; r++) begin
            iss_e = 1; iss_a = 5'(r);
            step();
        end
        idle();
        rs1_a = 1; rs2_a = 4;
        exp("iss4_cnt", S_CNT, 4); exp("iss4_r1", S_R1, 0); exp("iss4_r2", S_R2, 0);
        step();
        flush = 1; iss_e = 1; iss_a = 9;
        exp("flush_same_cnt", S_CNT, 4);
        step();
        idle();
        rs1_a = 9; rs2_a = 1;
        exp("flush_cnt", S_CNT, 1); exp("flush_r9", S_R1, 0); exp("flush_r1", S_R2, 1);
        step();
        rs1_a = 5; rs2_a = 3;
        exp("flush_data5", S_O1, 32'hDEADBEEF); exp("flush_data3", S_O2, 32'h12345678);
        exp("flush_r5", S_R1, 1); exp("flush_r3", S_R2, 1);
        step();
        // fill the scoreboard to its upper bound, re-issue, flush alone
        for (int r = 1; r < 32; r++) begin
            iss_e = 1; iss_a = 5'(r);
            step();
        end
        iss_a = 1;
        exp("full_cnt", S_CNT, 31);
        step();
        idle();
        exp("full_reiss_cnt", S_CNT, 31);
        step();
        flush = 1;
        step();
        idle();
        rs1_a = 31;
        exp("flush_all_cnt", S_CNT, 0); exp("flush_all_r31", S_R1, 1);
        step();
        // reset with three pending and a concurrent write
        for (int r = 9; r <= 11; r++) begin
            iss_e = 1; iss_a = 5'(r);
            step();
        end
        idle();
        exp("pre_rst_cnt", S_CNT, 3);
        step();
        rst = 1; rd_e = 1; rd_a = 12; rd_i = 32'h77; iss_e = 1; iss_a = 13;
        step();
        idle();
        rs1_a = 12; rs2_a = 5;
        exp("rst_wr_o1", S_O1, 0); exp("rst_wr_r1", S_R1, 1);
        exp("rst_data5", S_O2, 0); exp("rst_mid_cnt", S_CNT, 0);
        step();
        rs1_a = 9; rs2_a = 3;
        exp("rst_r9", S_R1, 1); exp("rst_data3", S_O2, 0); exp("rst_r13_cnt", S_CNT, 0);
        step();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
